// File: rtl/mux4_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux: one-hot registered grant,
// owner keeps the mux until it drops req, signals done, or hits MAX_HOLD cycles.
module mux4_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] search_base;
  logic [1:0] cand;
  logic [1:0] win;
  logic       found;
  logic       release_own;

  // On release the search restarts just past the owner; from IDLE it uses ptr.
  always_comb begin
    search_base = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
    found       = 1'b0;
    win         = search_base;
    cand        = search_base;
    // Walk offsets high to low so the lowest offset from the base wins last.
    for (int i = 3; i >= 0; i--) begin
      cand = search_base + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign release_own = !req[sel_q] || done || (hold_cnt_q == HOLD_LAST);

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << win;
          sel_d      = win;
          hold_cnt_d = 4'd0;
        end
      end
      GRANT: begin
        if (release_own) begin
          ptr_d = sel_q + 2'd1;
          if (found) begin
            gnt_d      = 4'b0001 << win;
            sel_d      = win;
            hold_cnt_d = 4'd0;
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            hold_cnt_d = 4'd0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = |gnt_q;

endmodule
